nmr_vote_ctrl: RTL and testbench

Parametrised, registered triple-modular-redundancy voter with fault localisation and graceful degradation. It votes three redundant datapath copies each valid sample and counts consecutive per-channel disagreements. A channel that stays the outlier for a programmable number of samples is retired, moving the block TMR → DUPLEX; a persistent mismatch in the surviving pair moves it to FAIL. It sits between the three redundant processing lanes and the downstream consumer, with the fault status readable by the system controller.

---
 rtl/nmr_vote_ctrl.sv | 144 ++++++++++++++
 tb/tb_nmr_vote_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nmr_vote_ctrl.sv
// Registered TMR voter with per-channel outlier counting, TMR -> DUPLEX -> FAIL degradation.
// Define TMR_INJECT_EN to compile in the inj_sel/inj_mask error-injection XOR.
module nmr_vote_ctrl #(
    parameter int DATA_W   = 27,
    parameter int FAULT_TH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    input  logic [2:0]        inj_sel,
    input  logic [DATA_W-1:0] inj_mask,
    input  logic              clr_fault,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tmr_error,
    output logic [2:0]        fault_vec,
    output logic [1:0]        mode
);
    typedef enum logic [1:0] {
        MODE_TMR    = 2'b00,
        MODE_DUPLEX = 2'b01,
        MODE_FAIL   = 2'b10
    } mode_t;

    localparam logic [3:0] TH = 4'(FAULT_TH);

    logic [DATA_W-1:0] ea, eb, ec;

`ifdef TMR_INJECT_EN
    assign ea = data_a ^ (inj_sel[0] ? inj_mask : '0);
    assign eb = data_b ^ (inj_sel[1] ? inj_mask : '0);
    assign ec = data_c ^ (inj_sel[2] ? inj_mask : '0);
`else
    logic unused_inj;
    assign unused_inj = ^{inj_sel, inj_mask};
    assign ea = data_a;
    assign eb = data_b;
    assign ec = data_c;
`endif

    // Sample streams are accepted unconditionally: in_valid qualifies a sample, there is no backpressure.
    mode_t             mode_q, mode_d;
    logic [2:0]        fault_d;
    logic [2:0][3:0]   cnt_q, cnt_d;
    logic [3:0]        dup_q, dup_d;
    logic [DATA_W-1:0] vote_d;
    logic              err_d;

    logic              ab, ac, bc;
    logic [1:0]        idx;
    logic [3:0]        cnt_inc;
    logic [3:0]        dup_inc;
    logic [DATA_W-1:0] lo, hi;

    assign ab = (ea == eb);
    assign ac = (ea == ec);
    assign bc = (eb == ec);

    // Live pair after one retirement: lo is the lower-index survivor, hi the other.
    assign lo = fault_vec[0] ? eb : ea;
    assign hi = fault_vec[2] ? eb : ec;

    assign mode = mode_q;

    always_comb begin
        mode_d  = mode_q;
        fault_d = fault_vec;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        vote_d  = data_out;
        err_d   = tmr_error;
        idx     = ab ? 2'd2 : (ac ? 2'd1 : 2'd0);
        cnt_inc = cnt_q[idx] + 4'd1;
        dup_inc = dup_q + 4'd1;
        if (in_valid) begin
            case (mode_q)
                MODE_TMR: begin
                    if (ab && bc) begin
                        vote_d = ea;
                        err_d  = 1'b0;
                        cnt_d  = '0;
                    end else if (ab || ac || bc) begin
                        vote_d     = bc ? eb : ea;
                        err_d      = 1'b0;
                        cnt_d      = '0;
                        cnt_d[idx] = cnt_inc;
                        if (cnt_inc >= TH) begin
                            fault_d[idx] = 1'b1;
                            cnt_d        = '0;
                            mode_d       = MODE_DUPLEX;
                        end
                    end else begin
                        vote_d = ea;
                        err_d  = 1'b1;
                    end
                end
                MODE_DUPLEX: begin
                    vote_d = lo;
                    if (lo == hi) begin
                        err_d = 1'b0;
                        dup_d = '0;
                    end else begin
                        err_d = 1'b1;
                        dup_d = dup_inc;
                        if (dup_inc >= TH) mode_d = MODE_FAIL;
                    end
                end
                default: begin
                    vote_d = lo;
                    err_d  = 1'b1;
                end
            endcase
        end
        if (clr_fault) begin
            mode_d  = MODE_TMR;
            fault_d = '0;
            cnt_d   = '0;
            dup_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_TMR;
            fault_vec <= '0;
            cnt_q     <= '0;
            dup_q     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            tmr_error <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            fault_vec <= fault_d;
            cnt_q     <= cnt_d;
            dup_q     <= dup_d;
            out_valid <= in_valid;
            data_out  <= vote_d;
            tmr_error <= err_d;
        end
    end
endmodule

// File: tb/tb_nmr_vote_ctrl.sv
// Directed bench for nmr_vote_ctrl (DATA_W=27, FAULT_TH=3); works with or without TMR_INJECT_EN.
module tb_nmr_vote_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [26:0] data_a, data_b, data_c;
    logic [2:0]  inj_sel;
    logic [26:0] inj_mask;
    logic        clr_fault;
    logic        out_valid;
    logic [26:0] data_out;
    logic        tmr_error;
    logic [2:0]  fault_vec;
    logic [1:0]  mode;

    int checks   = 0;
    int failures = 0;

    nmr_vote_ctrl #(.DATA_W(27), .FAULT_TH(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .data_a(data_a), .data_b(data_b), .data_c(data_c),
        .inj_sel(inj_sel), .inj_mask(inj_mask), .clr_fault(clr_fault),
        .out_valid(out_valid), .data_out(data_out), .tmr_error(tmr_error),
        .fault_vec(fault_vec), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1ns after the next rising edge.
    task automatic step(input logic v, input logic [26:0] a, input logic [26:0] b,
                        input logic [26:0] c, input logic clr);
        @(negedge clk);
        in_valid  = v;
        data_a    = a;
        data_b    = b;
        data_c    = c;
        clr_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [26:0] d, input logic e,
                           input logic [2:0] f, input logic [1:0] m);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_data"},  {5'b0, data_out},   {5'b0, d});
        chk({tag, "_err"},   {31'b0, tmr_error}, {31'b0, e});
        chk({tag, "_fault"}, {29'b0, fault_vec}, {29'b0, f});
        chk({tag, "_mode"},  {30'b0, mode},      {30'b0, m});
    endtask

    logic [26:0] a_inj;

    initial begin
        reset = 1'b1; in_valid = 1'b0; clr_fault = 1'b0;
        data_a = '0; data_b = '0; data_c = '0; inj_sel = '0; inj_mask = '0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data",  {5'b0, data_out},   32'd0);
        chk("rst_err",   {31'b0, tmr_error}, 32'd0);
        chk("rst_fault", {29'b0, fault_vec}, 32'd0);
        chk("rst_mode",  {30'b0, mode},      32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All agree
        step(1, 27'h1234567, 27'h1234567, 27'h1234567, 0);
        chk_out("agree", 27'h1234567, 0, 3'b000, 2'b00);
        // Idle cycle: out_valid drops, data holds
        step(0, 27'h0, 27'h1, 27'h2, 0);
        chk("idle_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_hold",  {5'b0, data_out},   32'h1234567);

`ifndef TMR_INJECT_EN
        // Injection compiled out: inj inputs must be ignored
        inj_sel = 3'b111; inj_mask = 27'h7F;
        step(1, 27'h42, 27'h42, 27'h42, 0);
        chk_out("noinj", 27'h42, 0, 3'b000, 2'b00);
        inj_sel = 3'b000; inj_mask = '0;
`endif

        // C outlier twice, agree, C outlier twice: no retirement
        step(1, 27'h10, 27'h10, 27'h11, 0);
        chk_out("c_out1", 27'h10, 0, 3'b000, 2'b00);
        step(1, 27'h10, 27'h10, 27'h11, 0);
        chk_out("c_out2", 27'h10, 0, 3'b000, 2'b00);
        step(1, 27'h20, 27'h20, 27'h20, 0);
        chk_out("c_agree", 27'h20, 0, 3'b000, 2'b00);
        step(1, 27'h10, 27'h10, 27'h11, 0);
        chk_out("c_out3", 27'h10, 0, 3'b000, 2'b00);
        step(1, 27'h10, 27'h10, 27'h11, 0);
        chk_out("c_out4", 27'h10, 0, 3'b000, 2'b00);

        // All differ: output A, error, counters untouched
        step(1, 27'h1, 27'h2, 27'h3, 0);
        chk_out("alldiff", 27'h1, 1, 3'b000, 2'b00);
        // C counter was held at 2, so one more C outlier retires channel 2
        step(1, 27'h10, 27'h10, 27'h11, 0);
        chk_out("c_trip", 27'h10, 0, 3'b100, 2'b01);
        // Clear with no valid sample
        step(0, 27'h0, 27'h0, 27'h0, 1);
        chk("clr_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_idle_fault", {29'b0, fault_vec}, 32'd0);
        chk("clr_idle_mode",  {30'b0, mode},      32'd0);

        // Channel A corrupted for 3 samples -> retire A, DUPLEX
`ifdef TMR_INJECT_EN
        inj_sel = 3'b001; inj_mask = 27'h0003FC0;
        a_inj = 27'h5;
`else
        a_inj = 27'h5 ^ 27'h0003FC0;
`endif
        step(1, a_inj, 27'h5, 27'h5, 0);
        chk_out("a_out1", 27'h5, 0, 3'b000, 2'b00);
        step(1, a_inj, 27'h5, 27'h5, 0);
        chk_out("a_out2", 27'h5, 0, 3'b000, 2'b00);
        step(1, a_inj, 27'h5, 27'h5, 0);
        chk_out("a_trip", 27'h5, 0, 3'b001, 2'b01);

        // DUPLEX, pair B/C agrees, A ignored
        step(1, 27'h1FF, 27'h7, 27'h7, 0);
        chk_out("dup_agree", 27'h7, 0, 3'b001, 2'b01);
        // Pair disagrees 3 times -> FAIL; output B (lower live)
        step(1, 27'h5, 27'h6, 27'h5, 0);
        chk_out("dup_diff1", 27'h6, 1, 3'b001, 2'b01);
        step(1, 27'h5, 27'h6, 27'h5, 0);
        chk_out("dup_diff2", 27'h6, 1, 3'b001, 2'b01);
        step(1, 27'h5, 27'h6, 27'h5, 0);
        chk_out("dup_trip", 27'h6, 1, 3'b001, 2'b10);
        inj_sel = 3'b000; inj_mask = '0;

        // FAIL: error even when pair agrees
        step(1, 27'h0, 27'h9, 27'h9, 0);
        chk_out("fail_agree", 27'h9, 1, 3'b001, 2'b10);
        // clr_fault with valid sample: output under FAIL, state cleared
        step(1, 27'h0, 27'hA, 27'hA, 1);
        chk_out("fail_clr", 27'hA, 1, 3'b000, 2'b00);
        step(1, 27'h33, 27'h33, 27'h33, 0);
        chk_out("post_clr", 27'h33, 0, 3'b000, 2'b00);

        // Mid-stream asynchronous reset
        @(negedge clk);
        in_valid = 1'b1; data_a = 27'h77; data_b = 27'h77; data_c = 27'h77;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data",  {5'b0, data_out},   32'd0);
        chk("mid_rst_err",   {31'b0, tmr_error}, 32'd0);
        chk("mid_rst_fault", {29'b0, fault_vec}, 32'd0);
        chk("mid_rst_mode",  {30'b0, mode},      32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("after_rst_data",  {5'b0, data_out},   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
